// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// bounded wait on pready, per-requester completion reporting.
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  state_t              state_r;
  state_t              state_s;
  logic                last_r;      // 1: req1 was granted last, so req0 wins a tie
  logic                grant_s;
  logic                any_s;
  logic                gidx_r;
  logic [CW-1:0]       cnt_r;
  logic                complete_s;
  logic                cerr_s;
  logic [DATA_W-1:0]   crdata_s;
  logic                psel_r;
  logic                penable_r;
  logic                pwrite_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r;
  logic                done0_r;
  logic                done1_r;
  logic [DATA_W-1:0]   rdata0_r;
  logic [DATA_W-1:0]   rdata1_r;
  logic                err0_r;
  logic                err1_r;

  // Round-robin grant selection and combinational accept
  always_comb begin
    any_s   = req0_valid | req1_valid;
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req0_ready = (state_r == IDLE) & req0_valid & ~grant_s;
    req1_ready = (state_r == IDLE) & req1_valid & grant_s;
  end

  // Next-state and completion decode
  always_comb begin
    state_s    = state_r;
    complete_s = 1'b0;
    cerr_s     = 1'b0;
    crdata_s   = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_s    = IDLE;
          complete_s = 1'b1;
          cerr_s     = pslverr;
          if (pwrite_r) begin
            crdata_s = {DATA_W{1'b0}};
          end else begin
            crdata_s = prdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
          state_s    = IDLE;
          complete_s = 1'b1;
          cerr_s     = 1'b1;
        end else begin
          state_s = ACCESS;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, arbitration pointer and ACCESS wait counter
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      gidx_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && any_s) begin
        last_r <= grant_s;
        gidx_r <= grant_s;
      end else begin
        last_r <= last_r;
        gidx_r <= gidx_r;
      end
      if ((state_r == ACCESS) && (state_s == ACCESS)) begin
        if (cnt_r != CNT_SAT) begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  // APB bus drivers; address/data/direction hold their last values while idle
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {ADDR_W{1'b0}};
      pwdata_r  <= {DATA_W{1'b0}};
    end else begin
      psel_r    <= (state_s != IDLE);
      penable_r <= (state_s == ACCESS);
      if ((state_r == IDLE) && any_s) begin
        if (grant_s) begin
          pwrite_r <= req1_write;
          paddr_r  <= req1_addr;
          pwdata_r <= req1_wdata;
        end else begin
          pwrite_r <= req0_write;
          paddr_r  <= req0_addr;
          pwdata_r <= req0_wdata;
        end
      end else begin
        pwrite_r <= pwrite_r;
        paddr_r  <= paddr_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  // Per-requester completion pulse with held read data and error
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
    end else begin
      done0_r <= complete_s & ~gidx_r;
      done1_r <= complete_s & gidx_r;
      if (complete_s && !gidx_r) begin
        rdata0_r <= crdata_s;
        err0_r   <= cerr_s;
      end else begin
        rdata0_r <= rdata0_r;
        err0_r   <= err0_r;
      end
      if (complete_s && gidx_r) begin
        rdata1_r <= crdata_s;
        err1_r   <= cerr_s;
      end else begin
        rdata1_r <= rdata1_r;
        err1_r   <= err1_r;
      end
    end
  end

  assign psel       = psel_r;
  assign penable    = penable_r;
  assign pwrite     = pwrite_r;
  assign paddr      = paddr_r;
  assign pwdata     = pwdata_r;
  assign req0_done  = done0_r;
  assign req1_done  = done1_r;
  assign req0_rdata = rdata0_r;
  assign req1_rdata = rdata1_r;
  assign req0_err   = err0_r;
  assign req1_err   = err1_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: small APB slave model with
// configurable wait states, error and stuck-ready behaviour.
module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          pclk = 1'b0;
  logic          prst;
  logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;

  logic [31:0] mem [0:15];
  logic stuck, err_cfg;
  int   wait_cfg;
  int   acc_cnt = 0;
  int   pen_cnt = 0;
  int   last_pen = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prst(prst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // APB slave: pready after wait_cfg low ACCESS cycles unless stuck
  assign pready  = !stuck && (acc_cnt >= wait_cfg);
  assign prdata  = mem[paddr[3:0]];
  assign pslverr = err_cfg;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr) mem[paddr[3:0]] <= pwdata;
    if (penable) pen_cnt <= pen_cnt + 1;
    else if (pen_cnt != 0) begin
      last_pen <= pen_cnt;
      pen_cnt  <= 0;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse
  always @(negedge pclk) begin
    if (prst && (req0_done || req1_done)) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {30'd0, req1_done, req0_done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_port", {30'd0, req1_done, req0_done}, 32'd1 << mon_e.idx);
        chk("rdata", (mon_e.idx == 1) ? req1_rdata : req0_rdata, mon_e.rdata);
        chk("err", {31'd0, (mon_e.idx == 1) ? req1_err : req0_err}, {31'd0, mon_e.err});
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic drive(input int idx, input logic v, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (idx == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  task automatic do_req(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat);
    exp_t e;
    int   n;
    logic got;
    drive(idx, 1'b1, wr, addr, wdata);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge pclk);
      if ((idx == 0) ? req0_ready : req1_ready) got = 1'b1;
      else begin
        @(posedge pclk);
        #1;
      end
      n++;
    end
    chk("grant_seen", {31'd0, got}, 32'd1);
    if (got) begin
      e.idx = idx; e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
      sbq.push_back(e);
      @(posedge pclk);
      #1;
      drive(idx, 1'b0, wr, addr, wdata);
      @(negedge pclk);
      chk("setup_phase", {30'd0, psel, penable}, 32'd2);
      chk("paddr", paddr, addr);
      chk("pwrite", {31'd0, pwrite}, {31'd0, wr});
      @(negedge pclk);
      chk("access_phase", {30'd0, psel, penable}, 32'd3);
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
        @(negedge pclk);
        n++;
      end
      chk("done_seen", sbq.size(), 32'd0);
      @(posedge pclk);
      #1;
      chk("penable_len", last_pen, lat - 2);
    end else begin
      drive(idx, 1'b0, wr, addr, wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   g;
    logic got;
    exp_t e;
    prst = 1'b0; stuck = 1'b0; err_cfg = 1'b0; wait_cfg = 0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_bus", {29'd0, psel, penable, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_hs", {26'd0, req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err}, 32'd0);
    chk("rst_rdata", req0_rdata | req1_rdata, 32'd0);
    @(posedge pclk);
    #1;
    prst = 1'b1;
    @(posedge pclk);
    #1;

    // write then read back, zero wait
    do_req(0, 1'b1, 32'd1, 32'd152, 32'd0, 1'b0, 3);
    do_req(0, 1'b0, 32'd1, 32'd0, 32'd152, 1'b0, 3);
    do_req(0, 1'b1, 32'd2, 32'h222, 32'd0, 1'b0, 3);
    do_req(1, 1'b1, 32'd3, 32'h333, 32'd0, 1'b0, 3);
    do_req(1, 1'b1, 32'd5, 32'd88, 32'd0, 1'b0, 3);

    // four wait states
    wait_cfg = 4;
    do_req(0, 1'b0, 32'd5, 32'd0, 32'd88, 1'b0, 7);
    wait_cfg = 0;

    // timeout, then a normal transfer
    stuck = 1'b1;
    do_req(1, 1'b0, 32'd5, 32'd0, 32'd0, 1'b1, 2 + TO);
    stuck = 1'b0;
    do_req(1, 1'b0, 32'd1, 32'd0, 32'd152, 1'b0, 3);

    // slave error on write, then ready on the last allowed cycle
    err_cfg = 1'b1;
    do_req(0, 1'b1, 32'd9, 32'h55, 32'd0, 1'b1, 3);
    err_cfg = 1'b0;
    wait_cfg = TO - 1;
    do_req(0, 1'b0, 32'd2, 32'd0, 32'h222, 1'b0, 2 + TO);
    wait_cfg = 0;

    // reset during ACCESS
    stuck = 1'b1;
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge pclk);
      if (req0_ready) got = 1'b1;
      else begin
        @(posedge pclk);
        #1;
      end
      n++;
    end
    chk("rst_test_grant", {31'd0, got}, 32'd1);
    @(posedge pclk);
    #1;
    drive(0, 1'b0, 1'b0, 32'd5, 32'd0);
    @(posedge pclk);
    #2;
    chk("pre_rst_access", {30'd0, psel, penable}, 32'd3);
    prst = 1'b0;
    #1;
    chk("mid_rst_bus", {30'd0, psel, penable}, 32'd0);
    chk("mid_rst_paddr", paddr, 32'd0);
    chk("mid_rst_rdata", req0_rdata, 32'd0);
    repeat (2) @(posedge pclk);
    #1;
    stuck = 1'b0;
    prst = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      chk("no_done_after_rst", {30'd0, req1_done, req0_done}, 32'd0);
    end
    @(posedge pclk);
    #1;

    // contention: both valid continuously, grants alternate starting at req0
    drive(0, 1'b1, 1'b0, 32'd2, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd3, 32'd0);
    g = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      n = 0;
      while (!got && n < 50) begin
        @(negedge pclk);
        if (req0_ready || req1_ready) got = 1'b1;
        else begin
          @(posedge pclk);
          #1;
        end
        n++;
      end
      chk("rr_grant", {30'd0, req1_ready, req0_ready}, 32'd1 << g);
      e.idx = g; e.rdata = (g == 1) ? 32'h333 : 32'h222; e.err = 1'b0; e.cyc = cyc + 3;
      sbq.push_back(e);
      @(posedge pclk);
      #1;
      if (k == 3) begin
        drive(0, 1'b0, 1'b0, 32'd2, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd3, 32'd0);
      end
      g = 1 - g;
    end
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    chk("rr_done_seen", sbq.size(), 32'd0);
    repeat (2) @(posedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
